// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the
// packed decoded bundle carried from decode into execute.
package decode_queue_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;

    // Memory access size/sign follows funct3 directly
    localparam logic [2:0] DMEM_B  = 3'd0;
    localparam logic [2:0] DMEM_H  = 3'd1;
    localparam logic [2:0] DMEM_W  = 3'd2;
    localparam logic [2:0] DMEM_BU = 3'd4;
    localparam logic [2:0] DMEM_HU = 3'd5;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] jump_offset;
        logic [3:0]  alu_ctrl;
        logic [2:0]  branch_ctrl;
        logic [2:0]  dmem_ctrl;
        logic        w_en;
        logic        op1_sel;
        logic        jump_en;
        logic        mw_en;
        logic        maddr_sel;
        logic        illegal;
    } dec_t;

    localparam int DEC_BUNDLE_W = $bits(dec_t);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    function automatic logic [3:0] alu_sel(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] r;
        unique case (f3)
            3'b000: r = alt ? ALU_SUB : ALU_ADD;
            3'b001: r = ALU_SLL;
            3'b010: r = ALU_SLT;
            3'b011: r = ALU_SLTU;
            3'b100: r = ALU_XOR;
            3'b101: r = alt ? ALU_SRA : ALU_SRL;
            3'b110: r = ALU_OR;
            3'b111: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] br_sel(input logic [2:0] f3);
        logic [2:0] r;
        unique case (f3)
            3'b000:  r = BR_EQ;
            3'b001:  r = BR_NE;
            3'b100:  r = BR_LT;
            3'b101:  r = BR_GE;
            3'b110:  r = BR_LTU;
            3'b111:  r = BR_GEU;
            default: r = BR_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I base decoder: one instruction word in,
// one packed control/immediate bundle out.
module decode_queue_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'b0};
    assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.rd       = inst[11:7];
        dec.alu_ctrl = ALU_ADD;
        unique case (1'b1)
            opc == OPC_LUI: begin
                dec.imm      = u_imm;
                dec.alu_ctrl = ALU_PASS;
                dec.w_en     = 1'b1;
                dec.op1_sel  = 1'b1;
            end
            opc == OPC_AUIPC: begin
                dec.imm     = u_imm;
                dec.w_en    = 1'b1;
                dec.op1_sel = 1'b1;
            end
            opc == OPC_JAL: begin
                dec.imm         = j_imm;
                dec.jump_offset = j_imm;
                dec.w_en        = 1'b1;
                dec.jump_en     = 1'b1;
            end
            opc == OPC_JALR: begin
                dec.imm         = i_imm;
                dec.jump_offset = i_imm;
                dec.w_en        = 1'b1;
                dec.jump_en     = 1'b1;
                dec.op1_sel     = 1'b1;
            end
            opc == OPC_BRANCH: begin
                dec.imm         = b_imm;
                dec.jump_offset = b_imm;
                dec.branch_ctrl = br_sel(f3);
            end
            opc == OPC_LOAD: begin
                dec.imm       = i_imm;
                dec.dmem_ctrl = f3;
                dec.w_en      = 1'b1;
                dec.op1_sel   = 1'b1;
                dec.maddr_sel = 1'b1;
            end
            opc == OPC_STORE: begin
                dec.imm       = s_imm;
                dec.dmem_ctrl = f3;
                dec.mw_en     = 1'b1;
                dec.op1_sel   = 1'b1;
                dec.maddr_sel = 1'b1;
            end
            opc == OPC_OP_IMM: begin
                // Only shifts use funct7[5] in the immediate form
                dec.imm      = i_imm;
                dec.alu_ctrl = alu_sel(f3, (f3 == 3'b101) && inst[30]);
                dec.w_en     = 1'b1;
                dec.op1_sel  = 1'b1;
            end
            opc == OPC_OP: begin
                dec.alu_ctrl = alu_sel(f3, inst[30]);
                dec.w_en     = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: instruction FIFO feeding the decoder, with a
// registered output bundle handshaked to execute.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit ILL_CHECK = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_imm,
    output logic [31:0]                out_jump_offset,
    output logic [3:0]                 out_alu_ctrl,
    output logic [2:0]                 out_branch_ctrl,
    output logic [2:0]                 out_dmem_ctrl,
    output logic                       out_w_en,
    output logic                       out_op1_sel,
    output logic                       out_jump_en,
    output logic                       out_mw_en,
    output logic                       out_maddr_sel,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fifo_entry_t   mem [DEPTH];
    fifo_entry_t   head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [31:0]   pc_q;
    dec_t          dec_q;
    dec_t          dec_raw;
    dec_t          dec_n;
    logic          push;
    logic          pop;

    assign push = in_valid && in_ready_q;
    assign pop  = (cnt != '0) && (!out_valid_q || out_ready);
    assign head = mem[rd_ptr];

    decode_queue_decoder u_dec (
        .inst (head.inst),
        .dec  (dec_raw)
    );

    always_comb begin
        dec_n = dec_raw;
        if (ILL_CHECK) begin
            if (dec_raw.illegal) begin
                dec_n.w_en        = 1'b0;
                dec_n.mw_en       = 1'b0;
                dec_n.jump_en     = 1'b0;
                dec_n.branch_ctrl = BR_NONE;
            end
        end else begin
            dec_n.illegal = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= {in_pc, in_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt_nxt;
        end
    end

    // Registered so fetch never sees a path from out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else if (flush) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (cnt_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            dec_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            pc_q        <= head.pc;
            dec_q       <= dec_n;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready        = in_ready_q;
    assign count           = cnt;
    assign out_valid       = out_valid_q;
    assign out_pc          = pc_q;
    assign out_rs1         = dec_q.rs1;
    assign out_rs2         = dec_q.rs2;
    assign out_rd          = dec_q.rd;
    assign out_imm         = dec_q.imm;
    assign out_jump_offset = dec_q.jump_offset;
    assign out_alu_ctrl    = dec_q.alu_ctrl;
    assign out_branch_ctrl = dec_q.branch_ctrl;
    assign out_dmem_ctrl   = dec_q.dmem_ctrl;
    assign out_w_en        = dec_q.w_en;
    assign out_op1_sel     = dec_q.op1_sel;
    assign out_jump_en     = dec_q.jump_en;
    assign out_mw_en       = dec_q.mw_en;
    assign out_maddr_sel   = dec_q.maddr_sel;
    assign out_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed stimulus pushes expected
// bundles, a negedge monitor pops them on each output handshake.
module tb_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_jump_offset;
    logic [3:0]  out_alu_ctrl;
    logic [2:0]  out_branch_ctrl;
    logic [2:0]  out_dmem_ctrl;
    logic        out_w_en;
    logic        out_op1_sel;
    logic        out_jump_en;
    logic        out_mw_en;
    logic        out_maddr_sel;
    logic        out_illegal;
    logic [$clog2(DEPTH+1)-1:0] count;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .ILL_CHECK(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_imm         (out_imm),
        .out_jump_offset (out_jump_offset),
        .out_alu_ctrl    (out_alu_ctrl),
        .out_branch_ctrl (out_branch_ctrl),
        .out_dmem_ctrl   (out_dmem_ctrl),
        .out_w_en        (out_w_en),
        .out_op1_sel     (out_op1_sel),
        .out_jump_en     (out_jump_en),
        .out_mw_en       (out_mw_en),
        .out_maddr_sel   (out_maddr_sel),
        .out_illegal     (out_illegal),
        .count           (count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic [31:0] jo;
        logic        w_en;
        logic        op1_sel;
        logic        jump_en;
        logic        mw_en;
        logic        illegal;
        logic        full;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(
        input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [31:0] imm, input logic [31:0] jo,
        input logic w_en, input logic op1_sel, input logic jump_en,
        input logic mw_en, input logic illegal, input logic full);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.imm = imm; e.jo = jo;
        e.w_en = w_en; e.op1_sel = op1_sel; e.jump_en = jump_en;
        e.mw_en = mw_en; e.illegal = illegal; e.full = full;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual_pc=0x%08h required=none",
                         out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_rd", 32'(out_rd), 32'(mon_e.rd));
                chk("out_rs1", 32'(out_rs1), 32'(mon_e.rs1));
                chk("out_w_en", 32'(out_w_en), 32'(mon_e.w_en));
                chk("out_jump_en", 32'(out_jump_en), 32'(mon_e.jump_en));
                chk("out_mw_en", 32'(out_mw_en), 32'(mon_e.mw_en));
                chk("out_illegal", 32'(out_illegal), 32'(mon_e.illegal));
                if (mon_e.full) begin
                    chk("out_imm", out_imm, mon_e.imm);
                    chk("out_jump_offset", out_jump_offset, mon_e.jo);
                    chk("out_op1_sel", 32'(out_op1_sel), 32'(mon_e.op1_sel));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] addi_x1(input int k);
        return 32'h0000_0093 | (32'(k) << 20);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // single addi x1,x0,5
        out_ready = 1'b1;
        exp_q.push_back(mk(32'h0, 5'd1, 5'd0, 32'h5, 32'h0,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        push(32'h0050_0093, 32'h0);
        chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
        tick();
        chk("single_drain_valid", 32'(out_valid), 32'd0);

        // add / sw / jal under backpressure
        out_ready = 1'b0;
        exp_q.push_back(mk(32'h4, 5'd3, 5'd1, 32'h0, 32'h0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h8, 5'd8, 5'd1, 32'h8, 32'h0,
                           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(32'hC, 5'd1, 5'd0, 32'h10, 32'h10,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        push(32'h0020_81B3, 32'h4);
        push(32'h0020_A423, 32'h8);
        push(32'h0100_00EF, 32'hC);
        chk("bp_count", 32'(count), 32'd2);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_pc", out_pc, 32'h4);
        tick();
        chk("stall_out_pc", out_pc, 32'h4);
        chk("stall_out_rd", 32'(out_rd), 32'd3);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("stream_rate", 32'(exp_q.size()), 32'd0);
        tick();
        chk("stream_idle_valid", 32'(out_valid), 32'd0);

        // fill to DEPTH plus the output register, then offer one more
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k == DEPTH + 1) begin
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("full_count", 32'(count), 32'(DEPTH));
            end else begin
                exp_q.push_back(mk(32'h100 + 32'(4 * k), 5'd1, 5'd0,
                                   32'(k + 16), 32'h0, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b1));
            end
            push(addi_x1(k + 16), 32'h100 + 32'(4 * k));
        end
        chk("full_count_after", 32'(count), 32'(DEPTH));
        chk("full_out_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        wait_drain("full_drain");
        repeat (3) tick();
        chk("full_idle_valid", 32'(out_valid), 32'd0);

        // flush with count=3 and a held output, plus a flush-cycle push
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(mk(32'h200 + 32'(4 * k), 5'd1, 5'd0, 32'(k),
                               32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            push(addi_x1(k), 32'h200 + 32'(4 * k));
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        push(32'h0070_0093, 32'h300);
        flush = 1'b0;
        exp_q.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("flush_idle_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(mk(32'h400, 5'd1, 5'd0, 32'h9, 32'h0,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        push(addi_x1(9), 32'h400);
        wait_drain("post_flush_drain");

        // illegal word followed by a normal one
        exp_q.push_back(mk(32'h500, 5'd31, 5'd31, 32'h0, 32'h0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h504, 5'd1, 5'd0, 32'h5, 32'h0,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        push(32'hFFFF_FFFF, 32'h500);
        push(32'h0050_0093, 32'h504);
        wait_drain("illegal_drain");
        repeat (3) tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
